// File: rtl/i2c_target.sv
// I2C target exposing NUM_REGS 8-bit registers. It never drives SCL and never stretches the clock.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample stability filter on SCL and SDA.
module i2c_target #(
  parameter logic [6:0]            ADDR      = 7'h20,
  parameter int unsigned           NUM_REGS  = 4,
  parameter logic [NUM_REGS*8-1:0] REG_RESET = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_oe_o,
  output logic [NUM_REGS*8-1:0]       regs_o,
  output logic                        wr_stb_o,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx_o,
  output logic                        busy_o
);

  localparam int unsigned     PtrW   = $clog2(NUM_REGS);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_s, sda_s;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Bus idles high, so the synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      if (scl_sync_q[1] == scl_hist_q[0] && scl_hist_q[0] == scl_hist_q[1]) begin
        scl_filt_q <= scl_sync_q[1];
      end
      if (sda_sync_q[1] == sda_hist_q[0] && sda_hist_q[0] == sda_hist_q[1]) begin
        sda_filt_q <= sda_sync_q[1];
      end
    end
  end

  assign scl_s = scl_filt_q;
  assign sda_s = sda_filt_q;
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_e                state_q;
  logic [3:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            rx_byte;
  logic [7:0]            cur_byte;
  logic [PtrW-1:0]       ptr_q;
  logic                  rw_q;
  logic                  ack_phase_q;
  logic                  oe_q;
  logic                  busy_q;
  logic                  wr_stb_q;
  logic [PtrW-1:0]       wr_idx_q;
  logic [NUM_REGS*8-1:0] regs_q;

  assign rx_byte  = {shift_q[6:0], sda_s};
  assign cur_byte = regs_q[{ptr_q, 3'b000} +: 8];

  // ack_phase_q: in ACK states, 0 = waiting for the fall after bit 8, 1 = ACK bit on the bus.
  // In StRdataAck, 1 = controller ACKed and the next byte loads on the coming fall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_phase_q <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_idx_q    <= '0;
      regs_q      <= REG_RESET;
    end else begin
      wr_stb_q <= 1'b0;
      if (stop_det) begin
        state_q <= StIdle;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        state_q     <= StAddr;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        oe_q        <= 1'b0;
        busy_q      <= 1'b1;
      end else begin
        case (state_q)
          StIdle: ;
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                ack_phase_q <= 1'b0;
                if (state_q == StAddr) begin
                  if (rx_byte[7:1] == ADDR) begin
                    rw_q    <= rx_byte[0];
                    state_q <= StAddrAck;
                  end else begin
                    state_q <= StIgnore;
                  end
                end else if (state_q == StPtr) begin
                  ptr_q   <= rx_byte[PtrW-1:0];
                  state_q <= StPtrAck;
                end else begin
                  regs_q[{ptr_q, 3'b000} +: 8] <= rx_byte;
                  wr_stb_q <= 1'b1;
                  wr_idx_q <= ptr_q;
                  ptr_q    <= ptr_q + PtrOne;
                  state_q  <= StWdataAck;
                end
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                oe_q        <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                if (state_q == StAddrAck && rw_q) begin
                  oe_q    <= ~cur_byte[7];
                  shift_q <= {cur_byte[6:0], 1'b0};
                  state_q <= StRdata;
                end else begin
                  oe_q    <= 1'b0;
                  state_q <= (state_q == StAddrAck) ? StPtr : StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                oe_q        <= 1'b0;
                ack_phase_q <= 1'b0;
                state_q     <= StRdataAck;
              end else begin
                oe_q    <= ~shift_q[7];
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          StRdataAck: begin
            if (scl_rise && !ack_phase_q) begin
              if (!sda_s) begin
                ptr_q       <= ptr_q + PtrOne;
                ack_phase_q <= 1'b1;
              end else begin
                state_q <= StIgnore;
              end
            end else if (scl_fall && ack_phase_q) begin
              ack_phase_q <= 1'b0;
              bit_cnt_q   <= '0;
              oe_q        <= ~cur_byte[7];
              shift_q     <= {cur_byte[6:0], 1'b0};
              state_q     <= StRdata;
            end
          end
          StIgnore: oe_q <= 1'b0;
          default: begin
            state_q <= StIdle;
            oe_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe_o = oe_q;
  assign regs_o   = regs_q;
  assign wr_stb_o = wr_stb_q;
  assign wr_idx_o = wr_idx_q;
  assign busy_o   = busy_q;

endmodule
